// File: rtl/fpadder_pipe.sv
// fpadder_pipe: three-stage pipelined floating-point adder with a valid/ready
// handshake. Round-to-nearest-even, subnormals flushed to zero, canonical quiet
// NaN for invalid operations. Stage 1 unpacks/aligns, stage 2 adds, stage 3
// normalises, rounds and packs.
module fpadder_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    localparam int W = EXP_W + MAN_W + 1
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] Sum,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   flags
);
    // Significand layout: {hidden, fraction, guard, round, sticky}
    localparam int SIG_W    = MAN_W + 4;
    localparam int SUM_W    = SIG_W + 1;
    localparam int LZ_W     = $clog2(SIG_W + 1);
    localparam int EXP_ONES = (1 << EXP_W) - 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Handshake: a stage may load when it is empty or its content leaves
    // ------------------------------------------------------------------
    logic v1_q, v2_q, v3_q;
    logic ready1, ready2, ready3;

    assign ready3    = !v3_q || out_ready;
    assign ready2    = !v2_q || ready3;
    assign ready1    = !v1_q || ready2;
    assign in_ready  = ready1;
    assign out_valid = v3_q;

    // ------------------------------------------------------------------
    // Stage 1: unpack, classify, order by magnitude, align
    // ------------------------------------------------------------------
    logic [W-1:0]       op      [2];
    logic               op_sign [2];
    logic [EXP_W-1:0]   op_exp  [2];
    logic [MAN_W-1:0]   op_frac [2];
    logic               op_zero [2];
    logic               op_inf  [2];
    logic               op_nan  [2];
    logic               op_snan [2];

    assign op[0] = A;
    assign op[1] = B;

    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
        assign op_sign[gi] = op[gi][W-1];
        assign op_exp[gi]  = op[gi][W-2:MAN_W];
        assign op_frac[gi] = op[gi][MAN_W-1:0];
        // Zero exponent covers true zeros and flushed subnormals alike
        assign op_zero[gi] = (op_exp[gi] == '0);
        assign op_inf[gi]  = (&op_exp[gi]) && (op_frac[gi] == '0);
        assign op_nan[gi]  = (&op_exp[gi]) && (op_frac[gi] != '0);
        assign op_snan[gi] = op_nan[gi] && !op_frac[gi][MAN_W-1];
    end

    logic               b_gt_a;
    logic               x_sign, y_sign;
    logic [EXP_W-1:0]   x_exp, y_exp, exp_diff;
    logic [MAN_W-1:0]   x_frac, y_frac;
    logic [SIG_W-1:0]   x_sig, y_sig, y_al;
    logic [2*SIG_W-1:0] y_shift;
    logic               s1_special_d;
    logic [W-1:0]       s1_spec_res_d;
    logic [3:0]         s1_spec_flags_d;

    assign b_gt_a = {op_exp[1], op_frac[1]} > {op_exp[0], op_frac[0]};

    // Swap so X has the larger magnitude, then shift Y right keeping sticky
    always_comb begin
        x_sign  = b_gt_a ? op_sign[1] : op_sign[0];
        y_sign  = b_gt_a ? op_sign[0] : op_sign[1];
        x_exp   = b_gt_a ? op_exp[1]  : op_exp[0];
        y_exp   = b_gt_a ? op_exp[0]  : op_exp[1];
        x_frac  = b_gt_a ? op_frac[1] : op_frac[0];
        y_frac  = b_gt_a ? op_frac[0] : op_frac[1];
        exp_diff = x_exp - y_exp;
        x_sig   = {1'b1, x_frac, 3'b000};
        y_sig   = {1'b1, y_frac, 3'b000};
        y_shift = {y_sig, {SIG_W{1'b0}}} >> exp_diff;
        if (int'(exp_diff) >= MAN_W + 3) begin
            // Everything of Y falls below the round bit: only sticky survives
            y_al = SIG_W'(1);
        end else begin
            y_al = y_shift[2*SIG_W-1:SIG_W] | SIG_W'(|y_shift[SIG_W-1:0]);
        end
    end

    // Results that bypass the arithmetic: NaN, Inf and zero operands
    always_comb begin
        s1_special_d    = 1'b1;
        s1_spec_res_d   = '0;
        s1_spec_flags_d = '0;
        if (op_nan[0] || op_nan[1]) begin
            s1_spec_res_d   = QNAN;
            s1_spec_flags_d = {op_snan[0] || op_snan[1], 3'b000};
        end else if (op_inf[0] && op_inf[1] && (op_sign[0] != op_sign[1])) begin
            s1_spec_res_d   = QNAN;
            s1_spec_flags_d = 4'b1000;
        end else if (op_inf[0]) begin
            s1_spec_res_d = A;
        end else if (op_inf[1]) begin
            s1_spec_res_d = B;
        end else if (op_zero[0] && op_zero[1]) begin
            s1_spec_res_d = {op_sign[0] && op_sign[1], {(W-1){1'b0}}};
        end else if (op_zero[0]) begin
            s1_spec_res_d = B;
        end else if (op_zero[1]) begin
            s1_spec_res_d = A;
        end else begin
            s1_special_d = 1'b0;
        end
    end

    logic               s1_special_q;
    logic [W-1:0]       s1_spec_res_q;
    logic [3:0]         s1_spec_flags_q;
    logic               s1_sign_q, s1_sub_q;
    logic [EXP_W-1:0]   s1_exp_q;
    logic [SIG_W-1:0]   s1_x_sig_q, s1_y_al_q;

    // Stage 1 register: operands captured only on an input transfer
    always_ff @(posedge CLK) begin
        if (RESET) begin
            v1_q            <= 1'b0;
            s1_special_q    <= 1'b0;
            s1_spec_res_q   <= '0;
            s1_spec_flags_q <= '0;
            s1_sign_q       <= 1'b0;
            s1_sub_q        <= 1'b0;
            s1_exp_q        <= '0;
            s1_x_sig_q      <= '0;
            s1_y_al_q       <= '0;
        end else if (ready1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                s1_special_q    <= s1_special_d;
                s1_spec_res_q   <= s1_spec_res_d;
                s1_spec_flags_q <= s1_spec_flags_d;
                s1_sign_q       <= x_sign;
                s1_sub_q        <= x_sign ^ y_sign;
                s1_exp_q        <= x_exp;
                s1_x_sig_q      <= x_sig;
                s1_y_al_q       <= y_al;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: significand add/subtract (X >= Y so never negative)
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] s2_sum_d;

    assign s2_sum_d = s1_sub_q ? ({1'b0, s1_x_sig_q} - {1'b0, s1_y_al_q})
                               : ({1'b0, s1_x_sig_q} + {1'b0, s1_y_al_q});

    logic               s2_special_q;
    logic [W-1:0]       s2_spec_res_q;
    logic [3:0]         s2_spec_flags_q;
    logic               s2_sign_q;
    logic [EXP_W-1:0]   s2_exp_q;
    logic [SUM_W-1:0]   s2_sum_q;

    // Stage 2 register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            v2_q            <= 1'b0;
            s2_special_q    <= 1'b0;
            s2_spec_res_q   <= '0;
            s2_spec_flags_q <= '0;
            s2_sign_q       <= 1'b0;
            s2_exp_q        <= '0;
            s2_sum_q        <= '0;
        end else if (ready2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                s2_special_q    <= s1_special_q;
                s2_spec_res_q   <= s1_spec_res_q;
                s2_spec_flags_q <= s1_spec_flags_q;
                s2_sign_q       <= s1_sign_q;
                s2_exp_q        <= s1_exp_q;
                s2_sum_q        <= s2_sum_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: normalise, round to nearest even, pack
    // ------------------------------------------------------------------
    function automatic logic [LZ_W-1:0] count_lz(input logic [SIG_W-1:0] v);
        logic [LZ_W-1:0] n;
        logic            found;
        n     = '0;
        found = 1'b0;
        for (int i = SIG_W - 1; i >= 0; i--) begin
            if (v[i]) found = 1'b1;
            else if (!found) n = n + LZ_W'(1);
        end
        return n;
    endfunction

    logic [LZ_W-1:0]  lz;
    logic [SIG_W-1:0] norm;
    logic [MAN_W+1:0] mant_r;
    logic [MAN_W-1:0] frac_r;
    logic             rnd_up, inexact;
    int               exp_n, exp_r;
    logic [W-1:0]     s3_res_d;
    logic [3:0]       s3_flags_d;

    // Normalise on carry-out or leading zeros, then round and detect range
    always_comb begin
        lz = count_lz(s2_sum_q[SIG_W-1:0]);
        if (s2_sum_q[SUM_W-1]) begin
            norm  = {s2_sum_q[SUM_W-1:2], s2_sum_q[1] | s2_sum_q[0]};
            exp_n = int'(s2_exp_q) + 1;
        end else begin
            norm  = s2_sum_q[SIG_W-1:0] << lz;
            exp_n = int'(s2_exp_q) - int'(lz);
        end
        rnd_up  = norm[2] && (norm[1] || norm[0] || norm[3]);
        inexact = norm[2] || norm[1] || norm[0];
        mant_r  = {1'b0, norm[SIG_W-1:3]} + (MAN_W+2)'(rnd_up);
        frac_r  = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
        exp_r   = mant_r[MAN_W+1] ? exp_n + 1 : exp_n;

        s3_res_d   = '0;
        s3_flags_d = '0;
        if (s2_special_q) begin
            s3_res_d   = s2_spec_res_q;
            s3_flags_d = s2_spec_flags_q;
        end else if (s2_sum_q == '0) begin
            // Exact cancellation always yields +0
            s3_res_d = '0;
        end else if (exp_r >= EXP_ONES) begin
            s3_res_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            s3_flags_d = 4'b0101;
        end else if (exp_r <= 0) begin
            s3_res_d   = {s2_sign_q, {(W-1){1'b0}}};
            s3_flags_d = 4'b0011;
        end else begin
            s3_res_d   = {s2_sign_q, exp_r[EXP_W-1:0], frac_r};
            s3_flags_d = {3'b000, inexact};
        end
    end

    logic [W-1:0] s3_sum_q;
    logic [3:0]   s3_flags_q;

    // Output register: holds while the consumer stalls
    always_ff @(posedge CLK) begin
        if (RESET) begin
            v3_q       <= 1'b0;
            s3_sum_q   <= '0;
            s3_flags_q <= '0;
        end else if (ready3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                s3_sum_q   <= s3_res_d;
                s3_flags_q <= s3_flags_d;
            end
        end
    end

    assign Sum   = s3_sum_q;
    assign flags = s3_flags_q;

endmodule

// File: tb/tb_fpadder_pipe.sv
// Testbench for fpadder_pipe: directed half/single precision vectors,
// a backpressured random stream against a real-arithmetic model, and reset
// in the middle of traffic.
module tb_fpadder_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a16, b16, sum16;
    logic        iv16, ir16, ov16, or16;
    logic [3:0]  fl16;
    logic [31:0] a32, b32, sum32;
    logic        iv32, ir32, ov32, or32;
    logic [3:0]  fl32;

    fpadder_pipe dut16 (
        .CLK(clk), .RESET(rst), .A(a16), .B(b16), .in_valid(iv16), .in_ready(ir16),
        .Sum(sum16), .out_valid(ov16), .out_ready(or16), .flags(fl16)
    );

    fpadder_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
        .CLK(clk), .RESET(rst), .A(a32), .B(b32), .in_valid(iv32), .in_ready(ir32),
        .Sum(sum32), .out_valid(ov32), .out_ready(or32), .flags(fl32)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic [3:0]  flags;
    } vec_t;

    vec_t hv [21];
    vec_t sv [3];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present one operation to an idle pipeline and wait for its result
    task automatic run_one(input bit sp, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] s, output logic [3:0] f, output int lat);
        @(negedge clk);
        if (sp) begin
            a32 = a; b32 = b; iv32 = 1'b1;
        end else begin
            a16 = a[15:0]; b16 = b[15:0]; iv16 = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        iv16 = 1'b0;
        iv32 = 1'b0;
        lat = 1;
        while (!(sp ? ov32 : ov16) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        s = sp ? sum32 : {16'h0000, sum16};
        f = sp ? fl32 : fl16;
    endtask

    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e;
        m = 1.0 + real'(h[9:0]) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return h[15] ? -m : m;
    endfunction

    // Returns {inexact, half}; operands are kept in the normal range
    function automatic logic [16:0] r2h(input real v);
        real  m, frac, rem;
        int   e, q;
        logic s;
        if (v == 0.0) return 17'h00000;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        frac = (m - 1.0) * 1024.0;
        q    = $rtoi(frac);
        rem  = frac - real'(q);
        if (rem > 0.5 || (rem == 0.5 && (q % 2) == 1)) q++;
        if (q == 1024) begin q = 0; e++; end
        return {rem != 0.0, s, 5'(e + 15), 10'(q)};
    endfunction

    logic [15:0] pa [10];
    logic [15:0] pb [10];
    logic [15:0] ps [10];
    logic [3:0]  pf [10];
    logic [31:0] rs;
    logic [3:0]  rf;
    int          lat;
    int          sent, rcv, inflight, cyc;
    logic        holding;
    logic [15:0] held_s;
    logic [3:0]  held_f;
    logic [16:0] mres;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // {a, b, expected sum, expected {invalid, overflow, underflow, inexact}}
        hv[0]  = '{32'h3C00, 32'h3C00, 32'h4000, 4'b0000}; // 1 + 1
        hv[1]  = '{32'h59EC, 32'h57A6, 32'h5CE0, 4'b0001}; // 189.5 + 122.375 = 311.875, tie to 312
        hv[2]  = '{32'h3C00, 32'h1000, 32'h3C00, 4'b0001}; // tie, stays even
        hv[3]  = '{32'h3C01, 32'h1000, 32'h3C02, 4'b0001}; // tie, rounds up to even
        hv[4]  = '{32'h3C00, 32'hBC00, 32'h0000, 4'b0000}; // exact cancel -> +0
        hv[5]  = '{32'h8000, 32'h8000, 32'h8000, 4'b0000}; // -0 + -0
        hv[6]  = '{32'h7BFF, 32'h7BFF, 32'h7C00, 4'b0101}; // overflow
        hv[7]  = '{32'h7C00, 32'hFC00, 32'h7E00, 4'b1000}; // Inf - Inf
        hv[8]  = '{32'h7C00, 32'h3C00, 32'h7C00, 4'b0000}; // Inf + finite
        hv[9]  = '{32'h0001, 32'h3C00, 32'h3C00, 4'b0000}; // subnormal as zero
        hv[10] = '{32'h0401, 32'h8400, 32'h0000, 4'b0011}; // result below normal range
        hv[11] = '{32'h7E00, 32'h3C00, 32'h7E00, 4'b0000}; // quiet NaN passes silently
        hv[12] = '{32'h7C01, 32'h3C00, 32'h7E00, 4'b1000}; // signalling NaN
        hv[13] = '{32'h4000, 32'hBC00, 32'h3C00, 4'b0000}; // 2 - 1, renormalise left
        hv[14] = '{32'h3C00, 32'h0400, 32'h3C00, 4'b0001}; // shift past all bits, sticky only
        hv[15] = '{32'h3FFF, 32'h1000, 32'h4000, 4'b0001}; // rounding carry bumps exponent
        hv[16] = '{32'h3800, 32'hBC00, 32'hB800, 4'b0000}; // 0.5 - 1, swapped order
        hv[17] = '{32'hFC00, 32'h3C00, 32'hFC00, 4'b0000}; // -Inf + finite
        hv[18] = '{32'h3C00, 32'h8000, 32'h3C00, 4'b0000}; // x + (-0)
        hv[19] = '{32'h8000, 32'h0000, 32'h0000, 4'b0000}; // -0 + +0
        hv[20] = '{32'hBC00, 32'hBC00, 32'hC000, 4'b0000}; // -1 + -1
        sv[0]  = '{32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000};
        sv[1]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101};
        sv[2]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 4'b0000};

        rst = 1'b1;
        a16 = '0; b16 = '0; iv16 = 1'b0; or16 = 1'b1;
        a32 = '0; b32 = '0; iv32 = 1'b0; or32 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset out_valid", ov16, 0);
        check("reset in_ready", ir16, 1);
        check("reset sum", sum16, 0);
        check("reset flags", fl16, 0);
        check("reset out_valid sp", ov32, 0);
        check("reset sum sp", sum32, 0);

        for (int i = 0; i < 21; i++) begin
            run_one(1'b0, hv[i].a, hv[i].b, rs, rf, lat);
            $display("half %0d: %h + %h -> %h flags=%b latency=%0d",
                     i, hv[i].a[15:0], hv[i].b[15:0], rs[15:0], rf, lat);
            check("half sum", rs, hv[i].sum);
            check("half flags", rf, hv[i].flags);
            check("half latency", lat, 3);
        end

        for (int i = 0; i < 3; i++) begin
            run_one(1'b1, sv[i].a, sv[i].b, rs, rf, lat);
            $display("single %0d: %h + %h -> %h flags=%b latency=%0d",
                     i, sv[i].a, sv[i].b, rs, rf, lat);
            check("single sum", rs, sv[i].sum);
            check("single flags", rf, sv[i].flags);
            check("single latency", lat, 3);
        end

        // Backpressured random stream, expectations from real arithmetic
        for (int i = 0; i < 10; i++) begin
            pa[i] = {1'($urandom_range(0, 1)), 5'($urandom_range(12, 18)), 10'($urandom_range(0, 1023))};
            pb[i] = {1'($urandom_range(0, 1)), 5'($urandom_range(12, 18)), 10'($urandom_range(0, 1023))};
            mres  = r2h(h2r(pa[i]) + h2r(pb[i]));
            ps[i] = mres[15:0];
            pf[i] = {3'b000, mres[16]};
        end
        sent = 0; rcv = 0; inflight = 0; cyc = 0;
        holding = 1'b0; held_s = '0; held_f = '0;
        while (rcv < 10 && cyc < 400) begin
            @(negedge clk);
            or16 = (cyc < 5) ? 1'b0 : ($urandom_range(0, 2) == 0);
            if (sent < 10) begin
                iv16 = 1'b1; a16 = pa[sent]; b16 = pb[sent];
            end else begin
                iv16 = 1'b0;
            end
            #1;
            check("stream in_ready", ir16, (inflight == 3 && !or16) ? 0 : 1);
            if (holding) begin
                check("stall hold sum", sum16, held_s);
                check("stall hold flags", fl16, held_f);
            end
            if (ov16 && or16) begin
                $display("stream %0d: %h + %h -> %h flags=%b (model %h %b)",
                         rcv, pa[rcv], pb[rcv], sum16, fl16, ps[rcv], pf[rcv]);
                check("stream sum", sum16, ps[rcv]);
                check("stream flags", fl16, pf[rcv]);
                rcv++;
                inflight--;
            end
            holding = ov16 && !or16;
            held_s  = sum16;
            held_f  = fl16;
            if (iv16 && ir16) begin
                sent++;
                inflight++;
            end
            cyc++;
        end
        check("stream results received", rcv, 10);
        @(negedge clk);
        iv16 = 1'b0;
        or16 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stream no extra result", ov16, 0);
        end

        // Reset with three operations in flight
        or16 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a16 = 16'h3C00; b16 = 16'h3C00; iv16 = 1'b1;
            @(negedge clk);
        end
        iv16 = 1'b0;
        check("pipe full before reset", ov16, 1);
        check("in_ready low when full", ir16, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("mid-stream reset: out_valid=%b in_ready=%b sum=%h", ov16, ir16, sum16);
        check("mid reset out_valid", ov16, 0);
        check("mid reset in_ready", ir16, 1);
        check("mid reset sum", sum16, 0);
        or16 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no stale result", ov16, 0);
        end
        run_one(1'b0, 32'h3C00, 32'h3800, rs, rf, lat);
        $display("after reset: 3c00 + 3800 -> %h flags=%b latency=%0d", rs[15:0], rf, lat);
        check("after reset sum", rs, 32'h3E00);
        check("after reset latency", lat, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
